// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm scheduler and its time helper.
package alarm_pkg;

   localparam int unsigned TIME_W        = 7;
   localparam int unsigned HOURS_PER_DAY = 24;
   localparam int unsigned MIN_PER_HOUR  = 60;
   localparam int unsigned SNOOZE_LIMIT  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RING = 2'd2
   } state_t;

   typedef struct packed {
      logic [TIME_W-1:0] h;
      logic [TIME_W-1:0] m;
   } hm_t;

endpackage

// File: rtl/time_add_wrap.sv
// Combinational h:m + K minutes with minute->hour and hour->day wrap (K < 60).
module time_add_wrap
   import alarm_pkg::*;
#(
   parameter int unsigned K = 5
) (
   input  logic [TIME_W-1:0] h,
   input  logic [TIME_W-1:0] m,
   output logic [TIME_W-1:0] h_sum,
   output logic [TIME_W-1:0] m_sum
);
   localparam int unsigned SUM_W = TIME_W + 1;

   logic [SUM_W-1:0] m_tot;
   logic [SUM_W-1:0] h_inc;

   always_comb begin
      m_tot = SUM_W'(m) + SUM_W'(K);
      h_inc = SUM_W'(h) + SUM_W'(1);
      m_sum = m_tot[TIME_W-1:0];
      h_sum = h;
      if (m_tot >= SUM_W'(MIN_PER_HOUR)) begin
         m_sum = TIME_W'(m_tot - SUM_W'(MIN_PER_HOUR));
         h_sum = (h_inc >= SUM_W'(HOURS_PER_DAY)) ? '0 : h_inc[TIME_W-1:0];
      end
   end

endmodule

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm scheduler: one shared comparator scans snooze + slots per minute change.
// Optional ALARM_SNOOZE_LIMIT_EN caps each ring chain at SNOOZE_LIMIT snoozes.
module alarm_scheduler
   import alarm_pkg::*;
#(
   parameter int unsigned NUM_SLOTS      = 4,
   parameter int unsigned SNOOZE_MIN     = 5,
   parameter int unsigned RING_TIMEOUT_S = 60
) (
   input  logic                         CLK,
   input  logic                         reset,
   input  logic                         sec_tick,
   input  logic [TIME_W-1:0]            h,
   input  logic [TIME_W-1:0]            m,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_SLOTS)-1:0] wr_slot,
   input  logic [TIME_W-1:0]            wr_h,
   input  logic [TIME_W-1:0]            wr_m,
   input  logic                         wr_on,
   input  logic                         alarm_on,
   input  logic                         dismiss,
   input  logic                         snooze,
   output logic                         ring,
   output logic [$clog2(NUM_SLOTS)-1:0] ring_slot,
   output logic                         busy
);
   localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
   localparam int unsigned IDX_W  = $clog2(NUM_SLOTS + 1);
   localparam int unsigned TMO_W  = 8;

   state_t               state, state_nxt;
   logic                 ring_nxt, busy_nxt;
   logic [TIME_W-1:0]    slot_h [NUM_SLOTS];
   logic [TIME_W-1:0]    slot_m [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] slot_on;
   hm_t                  snz_tgt;
   logic                 snz_valid;
   logic [SLOT_W-1:0]    snz_slot;
   logic [TIME_W-1:0]    tgt_h, tgt_m;
   logic [TIME_W-1:0]    m_prev;
   logic [IDX_W-1:0]     idx;
   logic [TMO_W-1:0]     tmo_cnt;
   logic                 min_chg, step_hit, step_is_snz, tmo_hit, snz_limit, snz_take;
   logic [SLOT_W-1:0]    step_slot;

   time_add_wrap #(.K(SNOOZE_MIN)) u_snooze_add (
      .h     (h),
      .m     (m),
      .h_sum (tgt_h),
      .m_sum (tgt_m)
   );

   assign min_chg  = (m != m_prev);
   assign tmo_hit  = sec_tick && (tmo_cnt == TMO_W'(RING_TIMEOUT_S - 1));
   assign snz_take = snooze && !dismiss && !tmo_hit && !snz_limit;

   // Shared comparator: step 0 checks the snooze target, step k checks slot k-1.
   always_comb begin
      step_is_snz = (idx == '0);
      step_slot   = snz_slot;
      step_hit    = 1'b0;
      if (step_is_snz) begin
         step_hit = snz_valid && (snz_tgt.h == h) && (snz_tgt.m == m);
      end else begin
         step_slot = SLOT_W'(idx - IDX_W'(1));
         step_hit  = slot_on[step_slot] && (slot_h[step_slot] == h) && (slot_m[step_slot] == m);
      end
      step_hit = step_hit && alarm_on;
   end

`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam int unsigned SCNT_W = $clog2(SNOOZE_LIMIT + 1);
   logic [SCNT_W-1:0] snz_cnt;

   assign snz_limit = (snz_cnt == SCNT_W'(SNOOZE_LIMIT));

   // Counts snoozes within one chain; a fresh slot ring starts a new chain.
   always_ff @(posedge CLK) begin
      if (reset) begin
         snz_cnt <= '0;
      end else if ((state == SCAN) && step_hit && !step_is_snz) begin
         snz_cnt <= '0;
      end else if (state == RING) begin
         if (dismiss || tmo_hit || (snooze && snz_limit)) snz_cnt <= '0;
         else if (snooze)                                 snz_cnt <= snz_cnt + SCNT_W'(1);
      end
   end
`else
   assign snz_limit = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (min_chg) state_nxt = SCAN;
         SCAN: begin
            if (step_hit)                             state_nxt = RING;
            else if (idx == IDX_W'(NUM_SLOTS))        state_nxt = IDLE;
         end
         RING:    if (dismiss || snooze || tmo_hit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ring_nxt = (state_nxt == RING);
      busy_nxt = (state_nxt == SCAN);
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         ring <= 1'b0;
         busy <= 1'b0;
      end else begin
         ring <= ring_nxt;
         busy <= busy_nxt;
      end
   end

   // Slot storage, scan index, snooze target and ring timeout.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_h[i] <= '0;
            slot_m[i] <= '0;
         end
         slot_on   <= '0;
         snz_valid <= 1'b0;
         snz_tgt   <= '0;
         snz_slot  <= '0;
         m_prev    <= m;
         idx       <= '0;
         tmo_cnt   <= '0;
         ring_slot <= '0;
      end else begin
         if (wr_en) begin
            slot_h[wr_slot]  <= wr_h;
            slot_m[wr_slot]  <= wr_m;
            slot_on[wr_slot] <= wr_on;
         end
         unique case (state)
            IDLE: begin
               if (min_chg) begin
                  m_prev <= m;
                  idx    <= '0;
               end
            end
            SCAN: begin
               if (step_hit) begin
                  ring_slot <= step_slot;
                  tmo_cnt   <= '0;
                  if (step_is_snz) snz_valid <= 1'b0;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            RING: begin
               m_prev <= m;
               if (sec_tick) tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (snz_take) begin
                  snz_valid <= 1'b1;
                  snz_tgt   <= '{h: tgt_h, m: tgt_m};
                  snz_slot  <= ring_slot;
               end else if (snooze && snz_limit && !dismiss && !tmo_hit) begin
                  snz_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler against a minutes-of-day reference model.
module tb_alarm_scheduler;
   localparam int NS  = 4;
   localparam int SW  = 2;
   localparam int SNZ = 5;
   localparam int TMO = 60;
`ifdef ALARM_SNOOZE_LIMIT_EN
   localparam int LIMIT = 3;
`else
   localparam int LIMIT = 1000000;
`endif

   logic          CLK = 1'b0;
   logic          reset, sec_tick, wr_en, wr_on, alarm_on, dismiss, snooze;
   logic [6:0]    h, m, wr_h, wr_m;
   logic [SW-1:0] wr_slot, ring_slot;
   logic          ring, busy;

   int nvec = 0;
   int nerr = 0;

   // Reference model state, kept as minutes-of-day.
   int mh[NS];
   int mmin[NS];
   bit mon[NS];
   bit msv;
   int msnz, msnz_slot;
   bit mring;
   int mslot, mtmo, mcnt, cur_h, cur_m;
   bit g_on;

   always #5 CLK = ~CLK;

   alarm_scheduler dut (
      .CLK       (CLK),
      .reset     (reset),
      .sec_tick  (sec_tick),
      .h         (h),
      .m         (m),
      .wr_en     (wr_en),
      .wr_slot   (wr_slot),
      .wr_h      (wr_h),
      .wr_m      (wr_m),
      .wr_on     (wr_on),
      .alarm_on  (alarm_on),
      .dismiss   (dismiss),
      .snooze    (snooze),
      .ring      (ring),
      .ring_slot (ring_slot),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NS; i++) begin
         mh[i] = 0; mmin[i] = 0; mon[i] = 1'b0;
      end
      msv = 1'b0; msnz = 0; msnz_slot = 0;
      mring = 1'b0; mslot = 0; mtmo = 0; mcnt = 0;
   endfunction

   // Which alarm (if any) fires for the current minute.
   function automatic void model_scan(output bit hit);
      int t;
      hit = 1'b0;
      if (mring || !g_on) return;
      t = cur_h * 60 + cur_m;
      if (msv && msnz == t) begin
         hit = 1'b1; mslot = msnz_slot; msv = 1'b0;
      end else begin
         for (int i = 0; i < NS; i++)
            if (!hit && mon[i] && (mh[i] * 60 + mmin[i]) == t) begin
               hit = 1'b1; mslot = i; mcnt = 0;
            end
      end
      if (hit) begin
         mring = 1'b1; mtmo = 0;
      end
   endfunction

   task automatic write_slot(input int s, input int hh, input int mm, input bit on);
      wr_en = 1'b1; wr_slot = SW'(s); wr_h = 7'(hh); wr_m = 7'(mm); wr_on = on;
      step();
      wr_en = 1'b0;
      mh[s] = hh; mmin[s] = mm; mon[s] = on;
   endtask

   // Move clock time to nh:nm, optionally writing slot ws mid-scan, and check the outcome.
   task automatic advance(input int nh, input int nm, input bit do_wr, input int ws,
                          input int wh, input int wm);
      bit was, hit;
      int first;
      was = mring;
      if (do_wr) begin
         mh[ws] = wh; mmin[ws] = wm; mon[ws] = 1'b1;
      end
      cur_h = nh; cur_m = nm;
      h = 7'(nh); m = 7'(nm);
      model_scan(hit);
      first = -1;
      for (int k = 0; k < NS + 4; k++) begin
         step();
         if (k == 0) chk("busy_in_scan", 32'(busy), 32'(!was));
         if (k == 0 && do_wr) begin
            wr_en = 1'b1; wr_slot = SW'(ws); wr_h = 7'(wh); wr_m = 7'(wm); wr_on = 1'b1;
         end
         if (k == 1) wr_en = 1'b0;
         if (ring === 1'b1 && first < 0) first = k;
      end
      chk("ring", 32'(ring), 32'(mring));
      if (mring) chk("ring_slot", 32'(ring_slot), 32'(mslot));
      if (hit) chk("latency_in_bound", 32'(first >= 0 && first + 1 <= NS + 3), 32'(1));
      chk("busy_after_scan", 32'(busy), 32'(0));
   endtask

   task automatic press(input bit d, input bit s);
      int t;
      dismiss = d; snooze = s;
      step();
      dismiss = 1'b0; snooze = 1'b0;
      if (mring) begin
         t = cur_h * 60 + cur_m;
         if (d || (s && mcnt >= LIMIT)) begin
            if (!d) msv = 1'b0;
            mcnt = 0;
         end else if (s) begin
            msv = 1'b1; msnz = (t + SNZ) % 1440; msnz_slot = mslot; mcnt++;
         end
         mring = 1'b0;
      end
      chk("ring_after_button", 32'(ring), 32'(mring));
   endtask

   initial begin
      int base, delta, t, r;
      reset = 1'b1; sec_tick = 1'b0; wr_en = 1'b0; wr_on = 1'b0; wr_slot = '0;
      wr_h = '0; wr_m = '0; dismiss = 1'b0; snooze = 1'b0; alarm_on = 1'b1; g_on = 1'b1;
      h = 7'd7; m = 7'd29; cur_h = 7; cur_m = 29;
      model_reset();
      repeat (3) step();
      reset = 1'b0;
      step();
      chk("reset_ring", 32'(ring), 32'(0));
      chk("reset_ring_slot", 32'(ring_slot), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));

      // Basic match, dismiss, no re-ring in the same minute.
      write_slot(2, 7, 30, 1'b1);
      advance(7, 30, 1'b0, 0, 0, 0);
      press(1'b1, 1'b0);
      repeat (10) step();
      chk("no_rering_same_minute", 32'(ring), 32'(mring));
      advance(7, 31, 1'b0, 0, 0, 0);

      // Priority and global enable.
      write_slot(1, 6, 0, 1'b1);
      write_slot(3, 6, 0, 1'b1);
      advance(5, 59, 1'b0, 0, 0, 0);
      advance(6, 0, 1'b0, 0, 0, 0);
      press(1'b1, 1'b0);
      advance(5, 59, 1'b0, 0, 0, 0);
      g_on = 1'b0; alarm_on = 1'b0;
      advance(6, 0, 1'b0, 0, 0, 0);
      g_on = 1'b1; alarm_on = 1'b1;

      // Snooze across midnight.
      write_slot(0, 23, 58, 1'b1);
      advance(23, 58, 1'b0, 0, 0, 0);
      press(1'b0, 1'b1);
      advance(23, 59, 1'b0, 0, 0, 0);
      for (int i = 0; i <= 3; i++) advance(0, i, 1'b0, 0, 0, 0);
      press(1'b1, 1'b0);
      advance(0, 2, 1'b0, 0, 0, 0);
      advance(0, 3, 1'b0, 0, 0, 0);

      // Timeout after RING_TIMEOUT_S ticks.
      advance(23, 58, 1'b0, 0, 0, 0);
      for (int i = 1; i <= TMO; i++) begin
         sec_tick = 1'b1;
         step();
         sec_tick = 1'b0;
         mtmo++;
         if (mtmo == TMO) begin
            mring = 1'b0; mcnt = 0;
         end
         if (i >= TMO - 1) chk("timeout_ring", 32'(ring), 32'(mring));
         step();
      end

      // Dismiss and snooze together: dismiss wins.
      advance(23, 59, 1'b0, 0, 0, 0);
      advance(23, 58, 1'b0, 0, 0, 0);
      press(1'b1, 1'b1);
      advance(23, 59, 1'b0, 0, 0, 0);
      for (int i = 0; i <= 3; i++) advance(0, i, 1'b0, 0, 0, 0);

      // Write to a not-yet-compared slot during the scan.
      advance(12, 0, 1'b1, 3, 12, 0);
      press(1'b1, 1'b0);

      // Randomized scenarios against the model.
      for (int it = 0; it < 20; it++) begin
         delta = 1 + int'($urandom_range(0, 58)) + 60 * int'($urandom_range(0, 3));
         base  = (cur_h * 60 + cur_m + delta) % 1440;
         for (int s = 0; s < NS; s++)
            if ($urandom_range(0, 1) == 1) begin
               t = (base + int'($urandom_range(0, 3))) % 1440;
               write_slot(s, t / 60, t % 60, $urandom_range(0, 3) != 0);
            end
         g_on = ($urandom_range(0, 4) != 0);
         alarm_on = g_on;
         for (int k = 0; k < 4; k++) begin
            t = (base + k) % 1440;
            advance(t / 60, t % 60, 1'b0, 0, 0, 0);
            if (mring) begin
               r = int'($urandom_range(0, 2));
               press(r != 1, r != 0);
            end
         end
      end
      g_on = 1'b1; alarm_on = 1'b1;

      // Reset while ringing clears everything.
      t = (cur_h * 60 + cur_m + 1) % 1440;
      write_slot(1, t / 60, t % 60, 1'b1);
      advance(t / 60, t % 60, 1'b0, 0, 0, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      model_reset();
      chk("reset_mid_ring", 32'(ring), 32'(0));
      chk("reset_mid_ring_slot", 32'(ring_slot), 32'(0));
      t = (t + 1) % 1440;
      advance(t / 60, t % 60, 1'b0, 0, 0, 0);
      t = (t + 1439) % 1440;
      advance(t / 60, t % 60, 1'b0, 0, 0, 0);

      // Snooze chain: limited to three snoozes when the limit is built in.
      write_slot(0, 10, 0, 1'b1);
      advance(10, 0, 1'b0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         press(1'b0, 1'b1);
         advance(10, 5 * i, 1'b0, 0, 0, 0);
      end
      if (mring) press(1'b1, 1'b0);
      chk("chain_end_ring", 32'(ring), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
